// File: rtl/seq_restoring_div_if.sv
// rtl/seq_restoring_div_if.sv - start/done handshake, operand and result bundle for seq_restoring_div
interface seq_restoring_div_if #(
  parameter int W = 8
) ();
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_div.sv
// rtl/seq_restoring_div.sv - W-cycle restoring divider, one quotient bit per edge
// Optional DIV_SIGNED_EN: two's complement operands via magnitude core plus sign fix-up.
module seq_restoring_div #(
  parameter int W = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_restoring_div_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic          busy_c, done_c;
  logic [W-1:0]  rem_r, q_r, dvsr_r;
  logic [CW-1:0] count;
  logic [W-1:0]  rem_sh;
  logic [W:0]    trial;
  logic [W-1:0]  rem_nx, q_nx;
  logic [W-1:0]  dvd_mag, dvs_mag;
  logic [W-1:0]  q_fin, r_fin;
  logic [W-1:0]  quotient_r, remainder_r;
  logic          dbz_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // DONE accepts a new start exactly like IDLE so results can stream back-to-back.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy_c = 1'b1;
        if (count == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.divisor == '0) ? S_DONE : S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The partial remainder never exceeds 2^(W-1)-1 before a shift, so W bits hold it.
  assign rem_sh = {rem_r[W-2:0], q_r[W-1]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dvsr_r};
  assign rem_nx = trial[W] ? rem_sh : trial[W-1:0];
  assign q_nx   = {q_r[W-2:0], ~trial[W]};

`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;

  assign dvd_mag = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[W-1]  ? -bus.divisor  : bus.divisor;
  assign q_fin   = q_neg ? -q_nx   : q_nx;
  assign r_fin   = r_neg ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= bus.dividend[W-1] ^ bus.divisor[W-1];
      r_neg <= bus.dividend[W-1];
    end
  end
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
  assign q_fin   = q_nx;
  assign r_fin   = rem_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r       <= '0;
      q_r         <= '0;
      dvsr_r      <= '0;
      count       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else if (accept) begin
      if (bus.divisor == '0) begin
        quotient_r  <= '1;
        remainder_r <= bus.dividend;
        dbz_r       <= 1'b1;
      end else begin
        rem_r  <= '0;
        q_r    <= dvd_mag;
        dvsr_r <= dvs_mag;
        count  <= CNT_INIT;
        dbz_r  <= 1'b0;
      end
    end else if (state == S_RUN) begin
      rem_r <= rem_nx;
      q_r   <= q_nx;
      count <= count - CW'(1);
      if (count == '0) begin
        quotient_r  <= q_fin;
        remainder_r <= r_fin;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule
